regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_if.sv | 35 +++
 rtl/regfile_sb.sv | 76 +++++++
 tb/tb_regfile_sb.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: writeback, read ports, issue and busy-scoreboard signals.
// The master side drives writes, read addresses and issues; the slave is the register file.
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              Reg_Write;
    logic [ADDR_W-1:0] Write_Reg_Addr;
    logic [DATA_W-1:0] Write_Reg_Data;
    logic [ADDR_W-1:0] Read_Reg_Addr1;
    logic [ADDR_W-1:0] Read_Reg_Addr2;
    logic [DATA_W-1:0] Read_Reg_Data1;
    logic [DATA_W-1:0] Read_Reg_Data2;
    logic              Issue_Valid;
    logic [ADDR_W-1:0] Issue_Dst_Addr;
    logic              Read_Busy1;
    logic              Read_Busy2;
    logic [ADDR_W:0]   Busy_Count;

    modport master (
        output Reg_Write, Write_Reg_Addr, Write_Reg_Data,
        output Read_Reg_Addr1, Read_Reg_Addr2,
        output Issue_Valid, Issue_Dst_Addr,
        input  Read_Reg_Data1, Read_Reg_Data2,
        input  Read_Busy1, Read_Busy2, Busy_Count
    );

    modport slave (
        input  Reg_Write, Write_Reg_Addr, Write_Reg_Data,
        input  Read_Reg_Addr1, Read_Reg_Addr2,
        input  Issue_Valid, Issue_Dst_Addr,
        output Read_Reg_Data1, Read_Reg_Data2,
        output Read_Busy1, Read_Busy2, Busy_Count
    );
endinterface

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with same-cycle write bypass and a per-register
// busy scoreboard (set on issue, cleared on writeback) plus a registered busy count.
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic          Clk,
    input logic          Clr,
    regfile_sb_if.slave  bus
);
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned CntW  = ADDR_W + 1;

    // Two-state storage so contents are zero from time zero, before any reset.
    bit   [DATA_W-1:0] mem_q [Depth];
    bit   [DATA_W-1:0] mem_d [Depth];
    logic [Depth-1:0]  busy_q, busy_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic wr_en, iss_en;
    logic byp1, byp2;

    always_comb begin
        wr_en  = bus.Reg_Write && !(ZERO_REG && (bus.Write_Reg_Addr == '0));
        iss_en = bus.Issue_Valid && !(ZERO_REG && (bus.Issue_Dst_Addr == '0));
    end

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr_en) begin
            mem_d[bus.Write_Reg_Addr]  = bus.Write_Reg_Data;
            busy_d[bus.Write_Reg_Addr] = 1'b0;
        end
        // Issue applied after writeback so a same-address issue leaves the bit set.
        if (iss_en) begin
            busy_d[bus.Issue_Dst_Addr] = 1'b1;
        end
        cnt_d = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            cnt_d = cnt_d + CntW'(busy_d[i]);
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        byp1 = bus.Reg_Write && (bus.Write_Reg_Addr == bus.Read_Reg_Addr1);
        byp2 = bus.Reg_Write && (bus.Write_Reg_Addr == bus.Read_Reg_Addr2);

        bus.Read_Reg_Data1 = byp1 ? bus.Write_Reg_Data : mem_q[bus.Read_Reg_Addr1];
        if ((ZERO_REG && (bus.Read_Reg_Addr1 == '0)) || Clr) begin
            bus.Read_Reg_Data1 = '0;
        end
        bus.Read_Reg_Data2 = byp2 ? bus.Write_Reg_Data : mem_q[bus.Read_Reg_Addr2];
        if ((ZERO_REG && (bus.Read_Reg_Addr2 == '0)) || Clr) begin
            bus.Read_Reg_Data2 = '0;
        end

        // A bypassed read already sees the pending value, so no hazard is reported.
        bus.Read_Busy1 = busy_q[bus.Read_Reg_Addr1] && !byp1 && !Clr;
        bus.Read_Busy2 = busy_q[bus.Read_Reg_Addr2] && !byp2 && !Clr;
        bus.Busy_Count = cnt_q;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Randomised scoreboard bench for regfile_sb: a driver pushes expected read/busy values
// from a reference model each cycle; a monitor pops and compares shortly after.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        rb1;
        logic        rb2;
        logic [5:0]  cnt;
        int          cyc;
    } exp_t;

    logic clk;
    logic Clr;
    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut (
        .Clk (clk),
        .Clr (Clr),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    exp_t exp_q[$];

    logic [31:0] m_regs [NR];
    bit          m_busy [NR];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] m_read(int a, bit we, int wa, logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic chk(input string nm, input int c, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, c, act, req);
        end
    endtask

    // One cycle: drive at the falling edge, record what the outputs must show before
    // the next rising edge, then advance the model across that edge.
    task automatic step(input bit clr, input bit we, input int wa, input logic [31:0] wd,
                        input int a1, input int a2, input bit iv, input int dst);
        exp_t e;
        @(negedge clk);
        Clr                = clr;
        bus.Reg_Write      = we;
        bus.Write_Reg_Addr = 5'(wa);
        bus.Write_Reg_Data = wd;
        bus.Read_Reg_Addr1 = 5'(a1);
        bus.Read_Reg_Addr2 = 5'(a2);
        bus.Issue_Valid    = iv;
        bus.Issue_Dst_Addr = 5'(dst);
        cyc++;
        if (clr) begin
            e.rd1 = '0; e.rd2 = '0; e.rb1 = 1'b0; e.rb2 = 1'b0; e.cnt = '0;
        end else begin
            e.rd1 = m_read(a1, we, wa, wd);
            e.rd2 = m_read(a2, we, wa, wd);
            e.rb1 = m_busy[a1] && !(we && wa == a1);
            e.rb2 = m_busy[a2] && !(we && wa == a2);
            e.cnt = 6'(m_count());
        end
        e.cyc = cyc;
        exp_q.push_back(e);
        if (clr) begin
            #4;
            Clr = 1'b0;
            for (int i = 0; i < NR; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end
        if (we && wa != 0) begin
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
        end
        if (iv && dst != 0) m_busy[dst] = 1'b1;
    endtask

    function automatic int rnd_addr();
        if ($urandom_range(0, 3) != 0) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, NR - 1));
    endfunction

    // Monitor: outputs are combinational and always valid, so compare every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rd1", e.cyc, bus.Read_Reg_Data1, e.rd1);
                chk("rd2", e.cyc, bus.Read_Reg_Data2, e.rd2);
                chk("busy1", e.cyc, 32'(bus.Read_Busy1), 32'(e.rb1));
                chk("busy2", e.cyc, 32'(bus.Read_Busy2), 32'(e.rb2));
                chk("busy_count", e.cyc, 32'(bus.Busy_Count), 32'(e.cnt));
            end
        end
    end

    initial begin
        int waited;
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        Clr                = 1'b1;
        bus.Reg_Write      = 1'b0;
        bus.Write_Reg_Addr = '0;
        bus.Write_Reg_Data = '0;
        bus.Read_Reg_Addr1 = '0;
        bus.Read_Reg_Addr2 = '0;
        bus.Issue_Valid    = 1'b0;
        bus.Issue_Dst_Addr = '0;

        // Reset with a write and issue presented: outputs must stay zero.
        step(1, 1, 5, 32'hAAAA_5555, 5, 5, 1, 5);
        step(0, 0, 0, 0, 5, 6, 0, 0);
        // Write then read.
        step(0, 1, 5, 32'hDEAD_BEEF, 1, 2, 0, 0);
        step(0, 0, 0, 0, 5, 5, 0, 0);
        // Same-cycle bypass.
        step(0, 1, 7, 32'h1234_5678, 7, 5, 0, 0);
        step(0, 0, 0, 0, 7, 7, 0, 0);
        // Zero register: write and issue both discarded.
        step(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Scoreboard set/clear.
        step(0, 0, 0, 0, 3, 4, 1, 3);
        step(0, 0, 0, 0, 3, 4, 1, 4);
        step(0, 0, 0, 0, 3, 4, 1, 3);
        step(0, 1, 3, 32'h0000_0033, 3, 4, 0, 0);
        step(0, 0, 0, 0, 3, 4, 0, 0);
        // Simultaneous writeback and issue on a busy register.
        step(0, 0, 0, 0, 9, 4, 1, 9);
        step(0, 1, 9, 32'h9999_0009, 9, 9, 1, 9);
        step(0, 0, 0, 0, 9, 4, 0, 0);
        // Writeback to a non-busy register.
        step(0, 1, 12, 32'h0C0C_0C0C, 12, 12, 0, 0);
        // Mid-operation reset with three busy registers and data loaded.
        step(0, 0, 0, 0, 9, 4, 1, 10);
        step(1, 1, 11, 32'h1111_1111, 9, 4, 1, 11);
        step(0, 1, 1, 32'h0101_0101, 1, 11, 0, 0);
        step(0, 0, 0, 0, 1, 9, 0, 0);

        for (int n = 0; n < 500; n++) begin
            step(($urandom_range(0, 63) == 0), $urandom_range(0, 1), rnd_addr(), $urandom,
                 rnd_addr(), rnd_addr(), $urandom_range(0, 1), rnd_addr());
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
